// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - slot timing constants and state/grant encodings shared by the scheduler
package sdram_pkg;

  localparam logic [3:0] SLOT_LEN   = 4'd10;
  localparam logic [3:0] STROBE_LEN = 4'd8;
  localparam logic [3:0] ACK_CYC    = 4'd8;

  typedef enum logic [1:0] {
    INIT_HOLD,
    INIT_RUN,
    IDLE,
    SLOT
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_DMA
  } grant_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with a single pending flag
module sdram_refresh_timer #(
  parameter int INTERVAL = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic pending
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // A wrap landing on the clear cycle must not lose a refresh, so set wins.
      if (wrap)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_sched.sv
// rtl/sdram_sched.sv - two-port SDRAM slot scheduler with init sequence and refresh priority
module sdram_sched
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 500,
  parameter int INIT_SLOTS       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic        sd_init,
  output logic        sd_ce,
  output logic        sd_refresh,
  output logic        sd_we,
  output logic [15:0] sd_addr,
  output logic        ready
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_SLOTS - 1);

  state_t      state;
  grant_t      gnt;
  logic [3:0]  slot_cyc;
  logic [15:0] init_cnt;
  logic        hold_cnt;
  logic        rr_cpu;
  logic        refresh_pending;
  logic        refresh_clr;

  assign refresh_clr = (state == IDLE) && refresh_pending;

  sdram_refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (refresh_clr),
    .pending(refresh_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT_HOLD;
      gnt        <= GNT_NONE;
      slot_cyc   <= 4'd0;
      init_cnt   <= 16'd0;
      hold_cnt   <= 1'b0;
      rr_cpu     <= 1'b1;
      sd_init    <= 1'b1;
      sd_ce      <= 1'b0;
      sd_refresh <= 1'b0;
      sd_we      <= 1'b0;
      sd_addr    <= 16'd0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      ready      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        INIT_HOLD: begin
          if (hold_cnt) begin
            state      <= INIT_RUN;
            sd_init    <= 1'b0;
            sd_refresh <= 1'b1;
            slot_cyc   <= 4'd0;
            init_cnt   <= 16'd0;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        INIT_RUN: begin
          if (slot_cyc == STROBE_LEN - 4'd1)
            sd_refresh <= 1'b0;
          if (slot_cyc == SLOT_LEN - 4'd1) begin
            slot_cyc <= 4'd0;
            if (init_cnt == INIT_LAST) begin
              state <= IDLE;
              ready <= 1'b1;
            end else begin
              init_cnt   <= init_cnt + 16'd1;
              sd_refresh <= 1'b1;
            end
          end else begin
            slot_cyc <= slot_cyc + 4'd1;
          end
        end
        IDLE: begin
          slot_cyc <= 4'd0;
          if (refresh_pending) begin
            state      <= SLOT;
            gnt        <= GNT_NONE;
            sd_refresh <= 1'b1;
            sd_we      <= 1'b0;
          end else if (cpu_req && (rr_cpu || !dma_req)) begin
            state   <= SLOT;
            gnt     <= GNT_CPU;
            sd_ce   <= 1'b1;
            sd_addr <= cpu_addr;
            sd_we   <= cpu_we;
            rr_cpu  <= 1'b0;
          end else if (dma_req) begin
            state   <= SLOT;
            gnt     <= GNT_DMA;
            sd_ce   <= 1'b1;
            sd_addr <= dma_addr;
            sd_we   <= dma_we;
            rr_cpu  <= 1'b1;
          end
        end
        SLOT: begin
          if (slot_cyc == STROBE_LEN - 4'd1) begin
            sd_ce      <= 1'b0;
            sd_refresh <= 1'b0;
          end
          if (slot_cyc == ACK_CYC - 4'd1) begin
            cpu_ack <= (gnt == GNT_CPU);
            dma_ack <= (gnt == GNT_DMA);
          end
          if (slot_cyc == SLOT_LEN - 4'd1) begin
            state    <= IDLE;
            sd_we    <= 1'b0;
            slot_cyc <= 4'd0;
          end else begin
            slot_cyc <= slot_cyc + 4'd1;
          end
        end
        default: state <= INIT_HOLD;
      endcase
    end
  end

endmodule

// File: doc/sdram_sched.md
SDRAM_SCHED -- requirements
Module: sdram_sched

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 500, meaning clock cycles between refresh requests.
REQ-002 SHALL have parameter INIT_SLOTS, default 32, meaning refresh-type slots issued during initialisation.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req in 1, cpu_addr in 16, cpu_we in 1, cpu_ack out 1, forming the CPU request port.
REQ-006 SHALL have ports dma_req in 1, dma_addr in 16, dma_we in 1, dma_ack out 1, forming the DMA request port.
REQ-007 SHALL have ports sd_init out 1, sd_ce out 1, sd_refresh out 1, sd_we out 1, sd_addr out 16, driving the downstream SDRAM controller.
REQ-008 SHALL have port ready out 1, high once initialisation has completed.

Function
REQ-009 Slot: SHALL be 10 cycles long, numbered 0..9. The strobe (sd_ce or sd_refresh) is high in cycles 0..7 and low in cycles 8..9. sd_addr and sd_we are stable for the whole slot.
REQ-010 FSM: SHALL have states INIT_HOLD, INIT_RUN, IDLE and SLOT. All outputs are registered.
REQ-011 INIT_HOLD: SHALL hold sd_init=1 for 2 cycles after reset deasserts, then go to INIT_RUN.
REQ-012 INIT_RUN: SHALL issue INIT_SLOTS back-to-back refresh slots with sd_ce=0, then set ready=1 and go to IDLE. Requests are ignored until then.
REQ-013 Refresh timer: SHALL count 0..REFRESH_INTERVAL-1 and wrap. On wrap it sets refresh_pending. If the flag is already set, the wrap is absorbed (no counting beyond one).
REQ-014 Arbitration: SHALL take place in IDLE only, with priority refresh_pending > round-robin(cpu, dma). The round-robin pointer favours the requester not granted last; after reset it favours cpu.
REQ-015 Grant, access: SHALL capture the winner's addr/we into sd_addr/sd_we and raise sd_ce in the next cycle (slot cycle 0), i.e. 1 cycle after req is sampled.
REQ-016 Grant, refresh: SHALL raise sd_refresh with sd_ce=0 and sd_we=0, and clear refresh_pending in the same cycle.
REQ-017 Ack: SHALL pulse the granted port's ack for exactly one cycle in slot cycle 8. Refresh slots produce no ack.
REQ-018 SHALL return to IDLE after slot cycle 9. Arbitration resumes in the following cycle, so the minimum slot-start spacing is 11 cycles.
REQ-019 Handshake: a requester holds req/addr/we stable until ack and drops req in the cycle after ack. A req still high 2 cycles after ack is a new request.
REQ-020 Simultaneous requests: when cpu_req and dma_req are both high, SHALL grant by the round-robin pointer. If refresh_pending is also set, the refresh goes first and both requests wait.
REQ-021 SHALL never assert sd_ce and sd_refresh in the same cycle.
REQ-022 Idle outputs: SHALL drive sd_ce=0, sd_refresh=0 and sd_we=0 while idle; sd_addr holds its last value.
REQ-023 A req deasserted before grant SHALL be treated as withdrawn and produce no ack.

Reset
REQ-024 Reset values: sd_init=1, sd_ce=0, sd_refresh=0, sd_we=0, sd_addr=0, cpu_ack=0, dma_ack=0, ready=0; state INIT_HOLD, refresh timer 0, refresh_pending=0, round-robin pointer on cpu.
REQ-025 Reset asserted mid-slot SHALL abort the slot immediately, issue no ack, and restart the full init sequence.

Structure
REQ-026 SHALL place slot length, strobe-high length, ack cycle and state encodings in shared package sdram_pkg.
REQ-027 SHALL implement the refresh timer as one sub-module, sdram_refresh_timer (interval parameter, pending flag, clear input).

Verification
REQ-028 Init: release reset -> sd_init high 2 cycles; 32 sd_refresh slots each 8 cycles high / 2 low; ready=1 after cycle 2+320; no sd_ce.
REQ-029 CPU read: cpu_req=1, cpu_addr=16'h1234, cpu_we=0 at cycle t in IDLE -> sd_ce high t+1..t+8 with sd_addr=16'h1234, sd_we=0; cpu_ack pulse at t+9 only.
REQ-030 Contention: cpu_req and dma_req (dma_we=1, dma_addr=16'hBEEF) both held, pointer=cpu -> cpu slot first, dma slot starts 11 cycles later with sd_we=1; next contention goes to cpu again.
REQ-031 Refresh priority: refresh_pending set while cpu_req high in IDLE -> refresh slot first (no ack), cpu slot starts 11 cycles later.
REQ-032 Refresh saturation: hold a 1000-cycle stream of DMA requests against interval 500 -> refresh slots interleave with at most one pending; sd_ce and sd_refresh are never both high.
REQ-033 Reset mid-slot: assert reset at slot cycle 4 -> sd_ce=0 next cycle, no ack, init sequence replays in full.
